// File: rtl/receipt_chain_sequencer_if.sv
// Bundles for the receipt ingress stream and for the link to the receipt integrity checker.
// master drives the request/data side; slave returns ready or the verdict.
interface receipt_ingress_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pre_mu;
  logic [31:0] in_post_mu;
  logic [7:0]  in_opcode;
  logic [31:0] in_operand;
  logic        in_last;

  modport master (output in_valid, in_pre_mu, in_post_mu, in_opcode, in_operand, in_last,
                  input  in_ready);
  modport slave  (input  in_valid, in_pre_mu, in_post_mu, in_opcode, in_operand, in_last,
                  output in_ready);
endinterface

interface receipt_checker_if;
  logic        chk_valid;
  logic [31:0] chk_pre_mu;
  logic [31:0] chk_post_mu;
  logic [7:0]  chk_opcode;
  logic [31:0] chk_operand;
  logic        chk_chain_mode;
  logic [31:0] chk_prev_post_mu;
  logic        chk_integrity_ok;
  logic        chk_chain_ok;
  logic [31:0] chk_error_code;

  modport master (output chk_valid, chk_pre_mu, chk_post_mu, chk_opcode, chk_operand,
                         chk_chain_mode, chk_prev_post_mu,
                  input  chk_integrity_ok, chk_chain_ok, chk_error_code);
  modport slave  (input  chk_valid, chk_pre_mu, chk_post_mu, chk_opcode, chk_operand,
                         chk_chain_mode, chk_prev_post_mu,
                  output chk_integrity_ok, chk_chain_ok, chk_error_code);
endinterface

// File: rtl/receipt_chain_sequencer.sv
// Streams a receipt chain one link at a time through a single integrity checker and
// reports a chain-level verdict, stopping at the first failing link or the last receipt.
module receipt_chain_sequencer #(
  parameter int MAX_RECEIPTS = 1024,
  parameter int CNT_W        = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [31:0]          init_mu_i,
  receipt_ingress_if.slave     ing,
  receipt_checker_if.master    chk,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 chain_pass_o,
  output logic [CNT_W-1:0]     fail_index_o,
  output logic [31:0]          fail_code_o,
  output logic [CNT_W-1:0]     receipt_count_o,
  output logic [31:0]          final_mu_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_ISSUE  = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [CNT_W:0]  MAX_L       = (CNT_W+1)'(MAX_RECEIPTS);
  localparam logic [31:0]     CODE_LENGTH = 32'd5;

  state_e            state_q, state_d;
  logic              in_ready_q, chk_valid_q, busy_q, done_q;

  logic [31:0]       rc_pre_q, rc_pre_d;
  logic [31:0]       rc_post_q, rc_post_d;
  logic [7:0]        rc_opcode_q, rc_opcode_d;
  logic [31:0]       rc_operand_q, rc_operand_d;
  logic              rc_last_q, rc_last_d;

  logic [31:0]       prev_mu_q, prev_mu_d;
  logic [31:0]       final_mu_q, final_mu_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  fail_index_q, fail_index_d;
  logic [31:0]       fail_code_q, fail_code_d;
  logic              chain_pass_q, chain_pass_d;

  logic [CNT_W:0]    count_inc_s;
  logic              link_ok_s;

  assign count_inc_s = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
  assign link_ok_s   = chk.chk_integrity_ok & chk.chk_chain_ok;

  // Next-state and datapath update; abort overrides everything and leaves status untouched.
  always_comb begin
    state_d      = state_q;
    rc_pre_d     = rc_pre_q;
    rc_post_d    = rc_post_q;
    rc_opcode_d  = rc_opcode_q;
    rc_operand_d = rc_operand_q;
    rc_last_d    = rc_last_q;
    prev_mu_d    = prev_mu_q;
    final_mu_d   = final_mu_q;
    count_d      = count_q;
    fail_index_d = fail_index_q;
    fail_code_d  = fail_code_q;
    chain_pass_d = chain_pass_q;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            prev_mu_d    = init_mu_i;
            final_mu_d   = init_mu_i;
            count_d      = {CNT_W{1'b0}};
            fail_index_d = {CNT_W{1'b0}};
            fail_code_d  = 32'd0;
            chain_pass_d = 1'b0;
            state_d      = S_ACCEPT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACCEPT: begin
          if (ing.in_valid && in_ready_q) begin
            rc_pre_d     = ing.in_pre_mu;
            rc_post_d    = ing.in_post_mu;
            rc_opcode_d  = ing.in_opcode;
            rc_operand_d = ing.in_operand;
            rc_last_d    = ing.in_last;
            state_d      = S_ISSUE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
        S_ISSUE: begin
          state_d = S_CHECK;
        end
        // Checker outputs are registered, so the verdict for the issued link is valid here.
        S_CHECK: begin
          if (link_ok_s) begin
            count_d    = count_inc_s[CNT_W-1:0];
            prev_mu_d  = rc_post_q;
            final_mu_d = rc_post_q;
            if (rc_last_q) begin
              chain_pass_d = 1'b1;
              state_d      = S_DONE;
            end else if (count_inc_s == MAX_L) begin
              fail_code_d  = CODE_LENGTH;
              fail_index_d = count_q;
              state_d      = S_DONE;
            end else begin
              state_d = S_ACCEPT;
            end
          end else begin
            fail_index_d = count_q;
            fail_code_d  = chk.chk_error_code;
            chain_pass_d = 1'b0;
            state_d      = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered control outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      chk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_ACCEPT);
      chk_valid_q <= (state_d == S_ISSUE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Receipt register, running mu and chain status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_pre_q     <= 32'd0;
      rc_post_q    <= 32'd0;
      rc_opcode_q  <= 8'd0;
      rc_operand_q <= 32'd0;
      rc_last_q    <= 1'b0;
      prev_mu_q    <= 32'd0;
      final_mu_q   <= 32'd0;
      count_q      <= {CNT_W{1'b0}};
      fail_index_q <= {CNT_W{1'b0}};
      fail_code_q  <= 32'd0;
      chain_pass_q <= 1'b0;
    end else begin
      rc_pre_q     <= rc_pre_d;
      rc_post_q    <= rc_post_d;
      rc_opcode_q  <= rc_opcode_d;
      rc_operand_q <= rc_operand_d;
      rc_last_q    <= rc_last_d;
      prev_mu_q    <= prev_mu_d;
      final_mu_q   <= final_mu_d;
      count_q      <= count_d;
      fail_index_q <= fail_index_d;
      fail_code_q  <= fail_code_d;
      chain_pass_q <= chain_pass_d;
    end
  end

  assign ing.in_ready         = in_ready_q;
  assign chk.chk_valid        = chk_valid_q;
  assign chk.chk_pre_mu       = rc_pre_q;
  assign chk.chk_post_mu      = rc_post_q;
  assign chk.chk_opcode       = rc_opcode_q;
  assign chk.chk_operand      = rc_operand_q;
  assign chk.chk_chain_mode   = 1'b1;
  assign chk.chk_prev_post_mu = prev_mu_q;

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign chain_pass_o    = chain_pass_q;
  assign fail_index_o    = fail_index_q;
  assign fail_code_o     = fail_code_q;
  assign receipt_count_o = count_q;
  assign final_mu_o      = final_mu_q;

endmodule

// File: tb/tb_receipt_chain_sequencer.sv
// Bench for receipt_chain_sequencer with a behavioural integrity checker and a queue of
// expected chain verdicts that is drained as each chain completes.
module tb_receipt_chain_sequencer;

  localparam int MAXR = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [31:0]   init_mu_i = 32'd0;
  logic          busy_o, done_o, chain_pass_o;
  logic [CW-1:0] fail_index_o, receipt_count_o;
  logic [31:0]   fail_code_o, final_mu_o;

  receipt_ingress_if ing ();
  receipt_checker_if chk ();

  receipt_chain_sequencer #(.MAX_RECEIPTS(MAXR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .init_mu_i(init_mu_i),
    .ing(ing), .chk(chk),
    .busy_o(busy_o), .done_o(done_o), .chain_pass_o(chain_pass_o),
    .fail_index_o(fail_index_o), .fail_code_o(fail_code_o),
    .receipt_count_o(receipt_count_o), .final_mu_o(final_mu_o)
  );

  always #5 clk = ~clk;

  // Checker model: opcodes 0x00-0x0F add the operand, 0xFF leaves mu unchanged, others invalid.
  function automatic logic [31:0] model_code(input logic [31:0] pre, post, prev, opnd,
                                             input logic [7:0] op);
    logic [32:0] s;
    s = {1'b0, pre} + {1'b0, opnd};
    if (!(op <= 8'h0F || op == 8'hFF)) return 32'd3;
    if (pre != prev) return 32'd2;
    if (op == 8'hFF) return (post == pre) ? 32'd0 : 32'd1;
    if (s[32]) return 32'd4;
    return (post == s[31:0]) ? 32'd0 : 32'd1;
  endfunction

  logic [31:0] mcode_s;
  assign mcode_s = model_code(chk.chk_pre_mu, chk.chk_post_mu, chk.chk_prev_post_mu,
                              chk.chk_operand, chk.chk_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk.chk_integrity_ok <= 1'b0;
      chk.chk_chain_ok     <= 1'b0;
      chk.chk_error_code   <= 32'd0;
    end else if (chk.chk_valid) begin
      chk.chk_error_code   <= mcode_s;
      chk.chk_integrity_ok <= !(mcode_s == 32'd1 || mcode_s == 32'd3 || mcode_s == 32'd4);
      chk.chk_chain_ok     <= (chk.chk_pre_mu == chk.chk_prev_post_mu);
    end
  end

  typedef struct {
    logic          pass;
    logic [CW-1:0] idx;
    logic [31:0]   code;
    logic [CW-1:0] cnt;
    logic [31:0]   mu;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] r_pre[8], r_post[8], r_opnd[8];
  logic [7:0]  r_op[8];
  logic        r_last[8];

  int hs_cnt, done_cnt, first_hs_cyc, done_cyc, field_err;
  bit timed_out;
  logic busy_after_abort;

  task automatic set_rc(input int i, input logic [31:0] pre, post, input logic [7:0] op,
                        input logic [31:0] opnd, input logic last);
    r_pre[i] = pre; r_post[i] = post; r_op[i] = op; r_opnd[i] = opnd; r_last[i] = last;
  endtask

  // Runs one chain from start until a few cycles after done/abort, recording what happened.
  task automatic run_chain(input logic [31:0] init, input int n, input int abort_issue,
                           input bit gaps, input bit poke_start);
    int k = 0, issue = 0, cyc = 0, tail = -1, abort_cyc = -10;
    bit stop = 1'b0;
    logic [31:0] exp_prev = init;
    hs_cnt = 0; done_cnt = 0; first_hs_cyc = -1; done_cyc = -1; field_err = 0;
    timed_out = 1'b0; busy_after_abort = 1'bx;
    @(negedge clk); start_i = 1'b1; init_mu_i = init;
    @(negedge clk); start_i = 1'b0;
    while (!stop) begin
      if (cyc == abort_cyc + 1) busy_after_abort = busy_o;
      if (done_o) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        if (tail < 0) tail = 3;
      end
      if (chk.chk_valid && issue < 8) begin
        if (chk.chk_pre_mu !== r_pre[issue] || chk.chk_post_mu !== r_post[issue] ||
            chk.chk_opcode !== r_op[issue] || chk.chk_operand !== r_opnd[issue] ||
            chk.chk_chain_mode !== 1'b1 || chk.chk_prev_post_mu !== exp_prev) field_err++;
        exp_prev = r_post[issue];
        if (issue == abort_issue) begin abort_i = 1'b1; abort_cyc = cyc; tail = 3; end
        issue++;
      end
      if (poke_start && cyc == 1) begin start_i = 1'b1; init_mu_i = 32'hDEAD_0000; end
      if (k < n && (!gaps || $urandom_range(0, 1) == 1)) begin
        ing.in_valid = 1'b1; ing.in_pre_mu = r_pre[k]; ing.in_post_mu = r_post[k];
        ing.in_opcode = r_op[k]; ing.in_operand = r_opnd[k]; ing.in_last = r_last[k];
      end else begin
        ing.in_valid = 1'b0; ing.in_pre_mu = $urandom; ing.in_post_mu = $urandom;
        ing.in_opcode = 8'($urandom); ing.in_operand = $urandom; ing.in_last = 1'($urandom);
      end
      if (ing.in_valid && ing.in_ready) begin
        if (hs_cnt == 0) first_hs_cyc = cyc;
        hs_cnt++; k++;
      end
      @(negedge clk);
      abort_i = 1'b0; start_i = 1'b0;
      cyc++;
      if (tail > 0) begin tail--; if (tail == 0) stop = 1'b1; end
      if (cyc > 300) begin timed_out = 1'b1; stop = 1'b1; end
    end
    ing.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy_o, done_o, chain_pass_o, fail_index_o, fail_code_o, receipt_count_o, final_mu_o,
         ing.in_ready, chk.chk_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b pass=%0b idx=%0d code=%0d cnt=%0d mu=%0h rdy=%0b cv=%0b, expected all 0",
               busy_o, done_o, chain_pass_o, fail_index_o, fail_code_o, receipt_count_o,
               final_mu_o, ing.in_ready, chk.chk_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ing.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%0b in_ready=%0b, expected 0 0", busy_o, ing.in_ready);
    end
  endtask

  task automatic test_pass_chain();
    exp_t e;
    set_rc(0, 32'd0, 32'd10, 8'h00, 32'd10, 1'b0);
    set_rc(1, 32'd10, 32'd15, 8'h07, 32'd5, 1'b0);
    set_rc(2, 32'd15, 32'd15, 8'hFF, 32'd0, 1'b1);
    sb.push_back('{1'b1, 3'd0, 32'd0, 3'd3, 32'd15});
    run_chain(32'd0, 3, -1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (timed_out || done_cnt !== 1) begin errors++; $display("FAIL pass_done: done pulses=%0d timeout=%0b, expected 1 0", done_cnt, timed_out); end
    checks++;
    if (done_cyc - first_hs_cyc !== 9) begin errors++; $display("FAIL pass_latency: done %0d cycles after first accept, expected 9", done_cyc - first_hs_cyc); end
    checks++;
    if (field_err !== 0) begin errors++; $display("FAIL pass_chk_fields: %0d bad issues, expected 0", field_err); end
    checks++;
    if (chain_pass_o !== e.pass || fail_index_o !== e.idx || fail_code_o !== e.code || receipt_count_o !== e.cnt || final_mu_o !== e.mu) begin
      errors++; $display("FAIL pass_status: pass=%0b idx=%0d code=%0d cnt=%0d mu=%0d, expected %0b %0d %0d %0d %0d",
        chain_pass_o, fail_index_o, fail_code_o, receipt_count_o, final_mu_o, e.pass, e.idx, e.code, e.cnt, e.mu);
    end
  endtask

  // Shared shape for single-failure chains: push the verdict, run, compare.
  task automatic test_fail_chain(input string name, input logic [31:0] init, input int n,
                                 input bit gaps, input bit poke, input exp_t want, input int exp_hs);
    exp_t e;
    sb.push_back(want);
    run_chain(init, n, -1, gaps, poke);
    e = sb.pop_front();
    checks++;
    if (timed_out || done_cnt !== 1 || hs_cnt !== exp_hs) begin
      errors++; $display("FAIL %s_flow: done=%0d accepted=%0d timeout=%0b, expected 1 %0d 0", name, done_cnt, hs_cnt, timed_out, exp_hs);
    end
    checks++;
    if (field_err !== 0) begin errors++; $display("FAIL %s_chk_fields: %0d bad issues, expected 0", name, field_err); end
    checks++;
    if (chain_pass_o !== e.pass || fail_index_o !== e.idx || fail_code_o !== e.code || receipt_count_o !== e.cnt || final_mu_o !== e.mu) begin
      errors++; $display("FAIL %s_status: pass=%0b idx=%0d code=%0d cnt=%0d mu=%0d, expected %0b %0d %0d %0d %0d",
        name, chain_pass_o, fail_index_o, fail_code_o, receipt_count_o, final_mu_o, e.pass, e.idx, e.code, e.cnt, e.mu);
    end
  endtask

  task automatic test_failures();
    set_rc(0, 32'd100, 32'd110, 8'h00, 32'd10, 1'b0);
    set_rc(1, 32'd110, 32'd125, 8'h00, 32'd5, 1'b0);
    set_rc(2, 32'd125, 32'd130, 8'h00, 32'd5, 1'b1);
    test_fail_chain("integrity", 32'd100, 3, 1'b1, 1'b0, '{1'b0, 3'd1, 32'd1, 3'd1, 32'd110}, 2);
    set_rc(0, 32'd0, 32'd10, 8'h00, 32'd10, 1'b0);
    set_rc(1, 32'd12, 32'd20, 8'h00, 32'd8, 1'b1);
    test_fail_chain("chain_break", 32'd0, 2, 1'b0, 1'b1, '{1'b0, 3'd1, 32'd2, 3'd1, 32'd10}, 2);
    set_rc(0, 32'd7, 32'd17, 8'h42, 32'd10, 1'b1);
    test_fail_chain("bad_opcode", 32'd7, 1, 1'b1, 1'b0, '{1'b0, 3'd0, 32'd3, 3'd0, 32'd7}, 1);
    set_rc(0, 32'hFFFF_FFF0, 32'h0000_0010, 8'h01, 32'h20, 1'b1);
    test_fail_chain("overflow", 32'hFFFF_FFF0, 1, 1'b0, 1'b0, '{1'b0, 3'd0, 32'd4, 3'd0, 32'hFFFF_FFF0}, 1);
  endtask

  task automatic test_length_limit();
    for (int i = 0; i < 5; i++) set_rc(i, 32'(i), 32'(i + 1), 8'h01, 32'd1, 1'b0);
    test_fail_chain("length", 32'd0, 5, 1'b0, 1'b0, '{1'b0, 3'd3, 32'd5, 3'd4, 32'd4}, 4);
  endtask

  task automatic test_abort();
    exp_t e;
    set_rc(0, 32'd0, 32'd10, 8'h00, 32'd10, 1'b0);
    set_rc(1, 32'd10, 32'd99, 8'h00, 32'd5, 1'b0);
    set_rc(2, 32'd99, 32'd100, 8'h00, 32'd1, 1'b1);
    sb.push_back('{1'b0, 3'd0, 32'd0, 3'd1, 32'd10});
    run_chain(32'd0, 3, 1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (timed_out || done_cnt !== 0 || busy_after_abort !== 1'b0 || hs_cnt !== 2) begin
      errors++; $display("FAIL abort_flow: done=%0d busy_next=%0b accepted=%0d timeout=%0b, expected 0 0 2 0", done_cnt, busy_after_abort, hs_cnt, timed_out);
    end
    checks++;
    if (chain_pass_o !== e.pass || fail_index_o !== e.idx || fail_code_o !== e.code || receipt_count_o !== e.cnt || final_mu_o !== e.mu) begin
      errors++; $display("FAIL abort_hold: pass=%0b idx=%0d code=%0d cnt=%0d mu=%0d, expected %0b %0d %0d %0d %0d",
        chain_pass_o, fail_index_o, fail_code_o, receipt_count_o, final_mu_o, e.pass, e.idx, e.code, e.cnt, e.mu);
    end
    @(negedge clk); start_i = 1'b1; abort_i = 1'b1; init_mu_i = 32'd3;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ing.in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_beats_start: busy=%0b in_ready=%0b, expected 0 0", busy_o, ing.in_ready);
    end
    set_rc(0, 32'd5, 32'd6, 8'h01, 32'd1, 1'b1);
    test_fail_chain("after_abort", 32'd5, 1, 1'b1, 1'b0, '{1'b1, 3'd0, 32'd0, 3'd1, 32'd6}, 1);
  endtask

  task automatic test_reset_mid();
    set_rc(0, 32'd0, 32'd10, 8'h00, 32'd10, 1'b0);
    @(negedge clk); start_i = 1'b1; init_mu_i = 32'd0;
    @(negedge clk); start_i = 1'b0;
    ing.in_valid = 1'b1; ing.in_pre_mu = r_pre[0]; ing.in_post_mu = r_post[0];
    ing.in_opcode = r_op[0]; ing.in_operand = r_opnd[0]; ing.in_last = r_last[0];
    @(negedge clk); ing.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (receipt_count_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL mid_progress: cnt=%0d busy=%0b, expected 1 1", receipt_count_o, busy_o);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (busy_o !== 1'b0 || receipt_count_o !== 3'd0 || final_mu_o !== 32'd0 || ing.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%0b cnt=%0d mu=%0d rdy=%0b, expected 0 0 0 0", busy_o, receipt_count_o, final_mu_o, ing.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    ing.in_valid = 1'b0; ing.in_pre_mu = 32'd0; ing.in_post_mu = 32'd0;
    ing.in_opcode = 8'd0; ing.in_operand = 32'd0; ing.in_last = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_pass_chain();
    test_failures();
    test_length_limit();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
